// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 3-stage RISC-V core.
//
// Owns the PC register and chooses the next PC. The choices are the reset
// vector, a hold during stall, a redirect from execute, or the sequential
// PC+4. It drives synchronous-read BIOS and IMEM ports with the next PC and
// hands the selected instruction word and its PC to decode.
//
// Ports:
//   clk, rst          core clock; synchronous active-high reset
//   stall             downstream cannot accept; hold PC and outputs
//   redirect_valid    execute resolved a jump / taken branch this cycle
//   redirect_target   byte address of the redirect
//   bios_addr/en/dout BIOS word address (pc_next[13:2]), enable, read data
//   imem_addr/en/dout IMEM word address (pc_next[15:2]), enable, read data
//   inst_d, pc_d      instruction to decode and its PC
//   inst_valid_d      inst_d is a real instruction (not a boot bubble)
//   misalign_d        one-cycle pulse: a misaligned redirect was accepted
//   fetch_count       valid instructions accepted by decode (wraps)
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h4000_0000,
  parameter int          BOOT_BUBBLES = 2,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [11:0] bios_addr,
  output logic        bios_en,
  input  logic [31:0] bios_dout,
  output logic [13:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_dout,
  output logic [31:0] inst_d,
  output logic [31:0] pc_d,
  output logic        inst_valid_d,
  output logic        misalign_d,
  output logic [31:0] fetch_count
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state;
  logic [3:0]  boot_cnt;
  logic [31:0] pc_f;
  logic        src_sel;
  logic [31:0] pc_next;
  logic        mem_en;
  logic        accept;

  // accept: an instruction leaves this stage at the coming edge
  assign accept = (state == RUN) && !stall;

  // Reset must still load the reset vector even when a stall is pending.
  assign mem_en = rst || !(stall && (state == RUN));

  always_comb begin
    pc_next = pc_f + 32'd4;
    if (rst || (state == BOOT))
      pc_next = RESET_PC;
    else if (stall)
      pc_next = pc_f;
    else if (redirect_valid)
      pc_next = {redirect_target[31:2], 2'b00};
  end

  assign bios_addr = pc_next[13:2];
  assign imem_addr = pc_next[15:2];
  assign bios_en   = mem_en;
  assign imem_en   = mem_en;

  // ---- fetch register stage: PC and source select track the memories ----
  always_ff @(posedge clk) begin
    if (mem_en) begin
      pc_f    <= pc_next;
      src_sel <= pc_next[30];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      boot_cnt    <= 4'(BOOT_BUBBLES - 1);
      fetch_count <= 32'd0;
      misalign_d  <= 1'b0;
    end else begin
      misalign_d <= accept && redirect_valid && (redirect_target[1:0] != 2'b00);
      if (accept)
        fetch_count <= fetch_count + 32'd1;
      if (state == BOOT) begin
        if (boot_cnt == 4'd0)
          state <= RUN;
        else
          boot_cnt <= boot_cnt - 4'd1;
      end
    end
  end

  // ---- decode handoff: word comes straight from the memory selected ----
  // Holding relies on the memories keeping their outputs while disabled.
  always_comb begin
    inst_valid_d = (state == RUN);
    pc_d         = pc_f;
    inst_d       = NOP_INST;
    if (state == RUN)
      inst_d = src_sel ? bios_dout : imem_dout;
  end

endmodule
